// File: rtl/apb_slave_regs_if.sv
// APB bus seen by one zero-wait-state completer: requester-driven phase signals and
// the completer's registered read data.
interface apb_slave_regs_if;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata);
  modport slave  (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata);
endinterface

// File: rtl/apb_slave_regs.sv
// APB completer: RW register bank, {err_cnt, wr_cnt} status word in the top slot, and a
// phase checker that pulses prot_err and counts every setup/access ordering violation.
module apb_slave_regs #(
  parameter int SLAVE_IDX = 0,
  parameter int NUM_REGS  = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  apb_slave_regs_if.slave  bus,
  output logic             prot_err,
  output logic [CNT_W-1:0] wr_count,
  output logic [1:0]       dbg_state
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(NUM_REGS - 1);

  // Handshake: a transfer is one sel&!en setup cycle followed by one sel&en access cycle
  // carrying identical {Pwrite, Paddr, Pwdata}; it completes at the edge ending the access
  // cycle (no Pready, never stalled). Any other phase ordering is a protocol violation.
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t           state, nxt_state;
  logic             sel, en, match;
  logic             latch, complete, err;
  logic             do_write, do_clear, rd_load;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_val;
  logic             lat_write;
  logic [31:0]      lat_addr, lat_wdata;
  logic [CNT_W-1:0] err_cnt, wr_cnt;
  logic [31:0]      regs [NUM_REGS-1];
  logic             unused_sel;

  assign sel        = bus.Pselx[SLAVE_IDX];
  assign unused_sel = ^bus.Pselx;
  assign en         = bus.Penable;
  assign idx        = bus.Paddr[IDX_W+1:2];
  assign match      = (bus.Pwrite == lat_write) && (bus.Paddr == lat_addr) &&
                      (bus.Pwdata == lat_wdata);
  assign wr_count   = wr_cnt;
  assign dbg_state  = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    latch     = 1'b0;
    complete  = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        if (sel && !en) begin
          nxt_state = SETUP;
          latch     = 1'b1;
        end else if (sel && en) begin
          err = 1'b1;
        end
      end
      SETUP: begin
        if (!sel) begin
          err       = 1'b1;
          nxt_state = IDLE;
        end else if (!en) begin
          err   = 1'b1;
          latch = 1'b1;
        end else if (match) begin
          nxt_state = ACCESS;
          complete  = 1'b1;
        end else begin
          err       = 1'b1;
          nxt_state = IDLE;
        end
      end
      ACCESS: begin
        if (!sel) begin
          nxt_state = IDLE;
        end else if (!en) begin
          nxt_state = SETUP;
          latch     = 1'b1;
        end else begin
          err       = 1'b1;
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    do_write = complete && lat_write && (idx != STATUS_IDX);
    do_clear = complete && lat_write && (idx == STATUS_IDX);
    rd_load  = sel && !en && !bus.Pwrite;
    rd_val   = '0;
    if (idx == STATUS_IDX) rd_val = 32'({err_cnt, wr_cnt});
    else                   rd_val = regs[idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      bus.Prdata <= '0;
      prot_err   <= 1'b0;
      err_cnt    <= '0;
      wr_cnt     <= '0;
      for (int i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
    end else begin
      if (latch) begin
        lat_write <= bus.Pwrite;
        lat_addr  <= bus.Paddr;
        lat_wdata <= bus.Pwdata;
      end
      prot_err   <= err;
      bus.Prdata <= rd_load ? rd_val : '0;
      // A status write wipes both counters, even an error counted on the same edge.
      if (do_clear) begin
        err_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        if (do_write) wr_cnt <= wr_cnt + CNT_W'(1);
        if (err && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
      end
      if (do_write) regs[idx] <= bus.Pwdata;
    end
  end
endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: directed phase sequences plus random register traffic, with
// read data checked against a register model through an expected-value queue.
module tb_apb_slave_regs;
  logic        clock = 1'b0;
  logic        reset;
  logic        prot_err;
  logic [15:0] wr_count;
  logic [1:0]  dbg_state;

  apb_slave_regs_if bus ();

  apb_slave_regs #(.SLAVE_IDX(0), .NUM_REGS(16), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .prot_err  (prot_err),
    .wr_count  (wr_count),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          failures = 0;
  int          pulses = 0;
  int          exp_pulses = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [15];
  logic [15:0] m_err, m_wr;

  always @(negedge clock) if (!reset && prot_err === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 15; i++) model[i] = '0;
    m_err = '0;
    m_wr  = '0;
  endtask

  task automatic model_err();
    if (m_err != 16'hFFFF) m_err++;
    exp_pulses++;
  endtask

  function automatic logic [31:0] exp_val(input logic [31:0] a);
    logic [3:0] i;
    i = a[5:2];
    if (i == 4'd15) return {m_err, m_wr};
    return model[i];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic e, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clock);
    #1;
    bus.Pselx   = s ? 4'b0001 : 4'b0100;
    bus.Penable = e;
    bus.Pwrite  = w;
    bus.Paddr   = a;
    bus.Pwdata  = d;
  endtask

  task automatic go_idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, 1'b1, a, d);
    drive(1'b1, 1'b1, 1'b1, a, d);
    if (a[5:2] == 4'd15) begin
      m_err = '0;
      m_wr  = '0;
    end else begin
      model[a[5:2]] = d;
      m_wr++;
    end
  endtask

  task automatic apb_read(input logic [31:0] a);
    logic [31:0] junk;
    junk = $urandom();
    drive(1'b1, 1'b0, 1'b0, a, junk);
    exp_q.push_back(exp_val(a));
    drive(1'b1, 1'b1, 1'b0, a, junk);
    @(negedge clock);
    check("rdata", bus.Prdata, exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, d;
    bus.Pselx = '0; bus.Penable = 0; bus.Pwrite = 0; bus.Paddr = '0; bus.Pwdata = '0;
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_prdata", bus.Prdata, 32'h0);
    check("rst_prot_err", 32'(prot_err), 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    reset = 1'b0;

    // basic write then read
    apb_write(32'h08, 32'hDEADBEEF);
    go_idle();
    apb_read(32'h08);
    go_idle();
    @(negedge clock);
    check("rd_after_access", bus.Prdata, 32'h0);
    check("wr_count_1", 32'(wr_count), 32'(m_wr));
    check("no_prot_err", 32'(pulses), 32'h0);

    // back-to-back write/read, no idle between
    apb_write(32'h04, 32'h1234_5678);
    apb_read(32'h04);
    go_idle();

    // enable without setup from IDLE
    drive(1'b1, 1'b1, 1'b0, 32'h0C, 32'h0);
    model_err();
    go_idle();
    @(negedge clock);
    check("idle_en_err", 32'(prot_err), 32'h1);
    apb_read(32'h3C);
    go_idle();

    // address changes between setup and access
    drive(1'b1, 1'b0, 1'b1, 32'h10, 32'hA5A5_0001);
    drive(1'b1, 1'b1, 1'b1, 32'h14, 32'hA5A5_0001);
    model_err();
    go_idle();
    @(negedge clock);
    check("addr_change_err", 32'(prot_err), 32'h1);
    apb_read(32'h10);
    apb_read(32'h14);
    go_idle();
    @(negedge clock);
    check("wr_count_abort", 32'(wr_count), 32'(m_wr));

    // enable held into a second access cycle: write lands, then error
    apb_write(32'h18, 32'h0BAD_F00D);
    drive(1'b1, 1'b1, 1'b1, 32'h18, 32'h0BAD_F00D);
    model_err();
    go_idle();
    apb_read(32'h18);
    go_idle();

    // repeated setup: error, re-latch, Prdata reloaded from second address
    drive(1'b1, 1'b0, 1'b0, 32'h04, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h08, 32'h0);
    model_err();
    exp_q.push_back(exp_val(32'h08));
    drive(1'b1, 1'b1, 1'b0, 32'h08, 32'h0);
    @(negedge clock);
    check("rpt_setup", bus.Prdata, exp_q.pop_front());
    go_idle();
    apb_read(32'h3C);
    go_idle();

    // status clear while an error pulse is pending
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    model_err();
    apb_write(32'h3C, 32'hFFFF_FFFF);
    go_idle();
    @(negedge clock);
    check("clr_wr_count", 32'(wr_count), 32'h0);
    apb_read(32'h3C);
    go_idle();

    // random register traffic, upper address bits randomised
    for (int n = 0; n < 24; n++) begin
      a = $urandom();
      a[5:2] = 4'($urandom_range(0, 14));
      d = $urandom();
      if ($urandom_range(0, 1) == 1) apb_write(a, d);
      else                           apb_read(a);
      if ($urandom_range(0, 2) == 0) go_idle();
    end
    go_idle();
    @(negedge clock);
    check("rand_wr_count", 32'(wr_count), 32'(m_wr));
    check("err_pulses", 32'(pulses), 32'(exp_pulses));
    apb_read(32'h3C);

    // reset during access of a write
    drive(1'b1, 1'b0, 1'b1, 32'h20, 32'hCAFE_CAFE);
    drive(1'b1, 1'b1, 1'b1, 32'h20, 32'hCAFE_CAFE);
    #1 reset = 1'b1;
    @(negedge clock);
    check("mid_rst_prdata", bus.Prdata, 32'h0);
    check("mid_rst_prot_err", 32'(prot_err), 32'h0);
    check("mid_rst_wr_count", 32'(wr_count), 32'h0);
    go_idle();
    reset = 1'b0;
    model_reset();
    apb_read(32'h20);
    apb_read(32'h08);
    apb_read(32'h3C);
    go_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
